seg7_scan_capture: RTL

Receive-side counterpart to the hex-to-7-segment decoder and digit scanner. Samples a 4-digit multiplexed, common-anode display bus (active-low anodes and segments, MC14495 glyph set), filters scan transitions, reverse-decodes each digit's segment pattern back to a hex nibble plus decimal point, and assembles a 16-bit word. Used in loopback self-test of the display path and as an on-chip monitor of what is physically being shown.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_rev_decode.sv | 30 +++
 rtl/seg7_scan_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: glyph table,
// display polarity and the scan-capture FSM state encoding.
package seg7_pkg;

    // Common-anode display: anodes and segments are both driven low to light.
    localparam logic AN_ACTIVE  = 1'b0;
    localparam logic SEG_ACTIVE = 1'b0;

    // MC14495 glyph set, active-high gfedcba; entry i is the pattern for nibble i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Scan-capture FSM: waiting for a stable sample, or already captured it.
    typedef enum logic [0:0] {
        ST_SETTLING = 1'b0,
        ST_CAPTURED = 1'b1
    } state_t;

    // True when exactly one of four bits is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        logic [2:0] ones;
        ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
        return (ones == 3'd1);
    endfunction

endpackage

// File: rtl/seg7_rev_decode.sv
// Reverse 7-segment decoder: active-high gfedcba pattern back to a hex nibble.
// hit is low for any pattern outside the glyph table (including blank).
module seg7_rev_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       hit
);

    logic [15:0] match_s;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match_s[gi] = (pattern == GLYPH_TABLE[gi]);
        end
    endgenerate

    // Glyphs are unique, so at most one match bit is set; OR-fold it into an index.
    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hit    = hit | match_s[i];
            nibble = nibble | ({4{match_s[i]}} & 4'(i));
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a 4-digit multiplexed common-anode display bus, waits for each scan
// step to settle, reverse-decodes the lit digit and assembles a 16-bit word.
// A frame is committed to the outputs once all four digits have been seen.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    input  logic        hold,
    output logic [15:0] hex,
    output logic [3:0]  points,
    output logic [3:0]  err,
    output logic        valid
);

    // cnt value seen on the edge that brings it to SETTLE-1, and its ceiling.
    localparam logic [3:0] CNT_CAPTURE = 4'(SETTLE - 2);
    localparam logic [3:0] CNT_MAX     = 4'(SETTLE);

    logic [11:0] smp_r;
    logic [3:0]  cnt_r;
    state_t      state_r;
    logic [3:0]  mask_r;
    logic [15:0] stage_hex_r;
    logic [3:0]  stage_pts_r;
    logic [3:0]  stage_err_r;

    logic        changed_s;
    logic        capture_s;
    logic        commit_s;
    logic        single_s;
    logic [3:0]  an_on_s;
    logic [7:0]  seg_on_s;
    logic [3:0]  dec_nib_s;
    logic        dec_hit_s;

    // The live bus differs from the held sample: this edge starts a new run.
    assign changed_s = ({an, seg} != smp_r);

    // Held sample converted to active-high anodes and segments.
    assign an_on_s  = smp_r[11:8] ^ {4{~AN_ACTIVE}};
    assign seg_on_s = smp_r[7:0]  ^ {8{~SEG_ACTIVE}};
    assign single_s = is_onehot4(an_on_s);

    // A capture happens once per run, on the edge that completes SETTLE samples.
    assign capture_s = (state_r == ST_SETTLING) && !changed_s && (cnt_r == CNT_CAPTURE);

    // All four digits staged: commit on the following edge.
    assign commit_s = (mask_r == 4'b1111);

    seg7_rev_decode u_rev_decode (
        .pattern (seg_on_s[6:0]),
        .nibble  (dec_nib_s),
        .hit     (dec_hit_s)
    );

    // Input register and settle counter; the counter saturates so a static
    // display never wraps back into a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_r <= 12'h000;
            cnt_r <= 4'd0;
        end else begin
            smp_r <= {an, seg};
            if (changed_s) begin
                cnt_r <= 4'd0;
            end else if (cnt_r >= CNT_MAX) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    // Two-state FSM: allow one capture per settled run, re-arm on any change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_SETTLING;
        end else begin
            case (state_r)
                ST_SETTLING: begin
                    if (capture_s) begin
                        state_r <= ST_CAPTURED;
                    end else begin
                        state_r <= ST_SETTLING;
                    end
                end
                ST_CAPTURED: begin
                    if (changed_s) begin
                        state_r <= ST_SETTLING;
                    end else begin
                        state_r <= ST_CAPTURED;
                    end
                end
                default: begin
                    state_r <= ST_SETTLING;
                end
            endcase
        end
    end

    // Staging registers and digit mask; only a single lit anode stores a digit.
    // A commit and a capture cannot share an edge, since a capture needs at
    // least one unchanged edge after the change that follows the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r      <= 4'b0000;
            stage_hex_r <= 16'h0000;
            stage_pts_r <= 4'b0000;
            stage_err_r <= 4'b0000;
        end else if (commit_s) begin
            mask_r <= 4'b0000;
        end else if (capture_s && single_s) begin
            for (int k = 0; k < 4; k++) begin
                if (an_on_s[k]) begin
                    stage_hex_r[4*k +: 4] <= dec_hit_s ? dec_nib_s : 4'h0;
                    stage_pts_r[k]        <= seg_on_s[7];
                    stage_err_r[k]        <= ~dec_hit_s;
                    mask_r[k]             <= 1'b1;
                end
            end
        end else begin
            mask_r <= mask_r;
        end
    end

    // Output registers: copy a completed frame unless hold discards it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hex    <= 16'h0000;
            points <= 4'b0000;
            err    <= 4'b0000;
            valid  <= 1'b0;
        end else if (commit_s && !hold) begin
            hex    <= stage_hex_r;
            points <= stage_pts_r;
            err    <= stage_err_r;
            valid  <= 1'b1;
        end else begin
            valid  <= 1'b0;
        end
    end

endmodule
